// File: rtl/popacc_pkg.sv
// Shared constants, types and helpers for the popcount accumulate/threshold block.
package popacc_pkg;

  localparam int WORD_W  = 128;
  localparam int POP_MAX = 128;
  localparam int POP_W   = 8;

  typedef logic [POP_W-1:0] pop_t;

  // Ceiling log2 for elaboration-time width calculations.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/popacc_thresh.sv
// Combinational binarized-neuron activation: popcount sum -> signed dot -> compare.
module popacc_thresh
  import popacc_pkg::*;
#(
  parameter  int BEATS = 4,
  parameter  int THR_W = 16,
  localparam int ACC_W = clog2(BEATS * WORD_W + 1),
  localparam int DOT_W = ACC_W + 1
) (
  input  logic [ACC_W-1:0]        acc,
  input  logic signed [THR_W-1:0] thr,
  output logic signed [DOT_W-1:0] dot,
  output logic                    act_bit
);

  // N = BEATS*128 bits; each matching bit counts +1, each mismatch -1.
  localparam logic [DOT_W-1:0] BIAS = DOT_W'(BEATS * WORD_W);

  logic signed [THR_W-1:0] dot_ext;

  // dot = 2*acc - N in DOT_W bits (exact for any legal acc), then signed compare.
  always_comb begin
    dot     = signed'({acc, 1'b0} - BIAS);
    dot_ext = THR_W'(dot);
    act_bit = (dot_ext >= thr);
  end

endmodule

// File: rtl/popcount_accum_threshold.sv
// Accumulates BEATS popcount beats per neuron and emits a thresholded activation bit.
// Optional feature macro: POPACC_DOT_OUT_EN adds a registered out_dot port.
module popcount_accum_threshold
  import popacc_pkg::*;
#(
  parameter  int BEATS = 4,
  parameter  int THR_W = 16,
  localparam int ACC_W = clog2(BEATS * WORD_W + 1),
  localparam int DOT_W = ACC_W + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  pop_t                    in_pop,
  input  logic                    in_last,
  input  logic signed [THR_W-1:0] in_thr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_bit,
`ifdef POPACC_DOT_OUT_EN
  output logic signed [DOT_W-1:0] out_dot,
`endif
  output logic                    err
);

  localparam int               CNT_W    = (BEATS > 1) ? clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS - 1);

  logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_bit_q, out_bit_d;
  logic                    err_q, err_d;
  logic                    is_final;
  logic                    accept;
  logic [ACC_W-1:0]        acc_next;
  logic signed [DOT_W-1:0] thr_dot;
  logic                    thr_bit;

  popacc_thresh #(
    .BEATS (BEATS),
    .THR_W (THR_W)
  ) u_thresh (
    .acc     (acc_next),
    .thr     (in_thr),
    .dot     (thr_dot),
    .act_bit (thr_bit)
  );

  // Handshake, accumulation, counter, error and output-register next state.
  always_comb begin
    is_final    = (beat_cnt_q == LAST_IDX);
    // Only a final beat can be blocked: it would overwrite a result not yet taken.
    in_ready    = !(out_valid_q && !out_ready && is_final);
    accept      = in_valid && in_ready;
    acc_next    = ((beat_cnt_q == '0) ? '0 : acc_q) + ACC_W'(in_pop);

    beat_cnt_d  = beat_cnt_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_bit_d   = out_bit_q;
    err_d       = err_q;

    if (accept) begin
      acc_d      = acc_next;
      beat_cnt_d = is_final ? '0 : beat_cnt_q + 1'b1;
      // The counter frames neurons; in_last is only cross-checked.
      if ((in_last != is_final) || (in_pop > POP_W'(POP_MAX))) begin
        err_d = 1'b1;
      end
    end

    if (accept && is_final) begin
      out_valid_d = 1'b1;
      out_bit_d   = thr_bit;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q  <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_bit_q   <= out_bit_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_bit   = out_bit_q;
  assign err       = err_q;

`ifdef POPACC_DOT_OUT_EN
  logic signed [DOT_W-1:0] dot_q, dot_d;

  // Dot value follows the same load/hold rule as out_bit.
  always_comb begin
    dot_d = dot_q;
    if (accept && is_final) begin
      dot_d = thr_dot;
    end
  end

  // Dot output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dot_q <= '0;
    end else begin
      dot_q <= dot_d;
    end
  end

  assign out_dot = dot_q;
`else
  logic unused_dot;
  assign unused_dot = ^thr_dot;
`endif

endmodule

// File: tb/tb_popcount_accum_threshold.sv
// Self-checking bench: cycle-level scoreboard built from per-neuron sums of pops.
module tb_popcount_accum_threshold;

  localparam int BEATS = 4;
  localparam int THR_W = 16;
  localparam int ACC_W = 10;
  localparam int DOT_W = 11;

  logic                    clk;
  logic                    rst_n;
  logic                    in_valid;
  logic                    in_ready;
  logic [7:0]              in_pop;
  logic                    in_last;
  logic signed [THR_W-1:0] in_thr;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_bit;
  logic                    err;
`ifdef POPACC_DOT_OUT_EN
  logic signed [DOT_W-1:0] out_dot;
`endif

  popcount_accum_threshold #(
    .BEATS (BEATS),
    .THR_W (THR_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pop    (in_pop),
    .in_last   (in_last),
    .in_thr    (in_thr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bit   (out_bit),
`ifdef POPACC_DOT_OUT_EN
    .out_dot   (out_dot),
`endif
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Reference model: pops of the neuron in progress plus the pending result.
  int                      q_pops[$];
  bit                      exp_valid;
  bit                      exp_bit;
  bit                      exp_err;
  logic signed [DOT_W-1:0] exp_dot;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q_pops.delete();
    exp_valid = 0;
    exp_bit   = 0;
    exp_err   = 0;
    exp_dot   = '0;
  endtask

  // One clock cycle: predict, let the edge happen, compare outputs.
  task automatic cyc(output bit accepted);
    bit exp_ready;
    int sum;
    int thr_i;
    #1;
    exp_ready = !(exp_valid && !out_ready && q_pops.size() == BEATS - 1);
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    accepted = in_valid && exp_ready;
    if (accepted) begin
      if (int'(in_pop) > 128) exp_err = 1;
      if (in_last != (q_pops.size() == BEATS - 1)) exp_err = 1;
      q_pops.push_back(int'(in_pop));
      if (q_pops.size() == BEATS) begin
        sum = 0;
        foreach (q_pops[i]) sum += q_pops[i];
        sum       = sum % (1 << ACC_W);
        exp_dot   = DOT_W'(2 * sum - BEATS * 128);
        thr_i     = int'(in_thr);
        exp_bit   = (int'(exp_dot) >= thr_i);
        exp_valid = 1;
        q_pops.delete();
      end else if (exp_valid && out_ready) begin
        exp_valid = 0;
      end
    end else if (exp_valid && out_ready) begin
      exp_valid = 0;
    end
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(exp_valid));
    chk("out_bit", 32'(out_bit), 32'(exp_bit));
    chk("err", 32'(err), 32'(exp_err));
`ifdef POPACC_DOT_OUT_EN
    chk("out_dot", 32'(out_dot), 32'(exp_dot));
`endif
  endtask

  // Present one beat until it is accepted (bounded).
  task automatic beat(input int pop, input bit last, input int thr, input bit rnd);
    bit acc;
    int n;
    n       = 0;
    acc     = 0;
    in_pop  = pop[7:0];
    in_last = last;
    in_thr  = THR_W'(thr);
    while (!acc && n < 200) begin
      if (rnd) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 1) != 0);
      end else begin
        in_valid = 1'b1;
      end
      cyc(acc);
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $error("FAIL beat_timeout observed=not_accepted expected=accepted");
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) cyc(acc);
  endtask

  task automatic neuron(input int p0, input int p1, input int p2, input int p3, input int thr);
    beat(p0, 0, thr, 0);
    beat(p1, 0, thr, 0);
    beat(p2, 0, thr, 0);
    beat(p3, 1, thr, 0);
  endtask

  // Asynchronous reset pulse away from clock edges; outputs must clear at once.
  task automatic do_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #2;
    model_reset();
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_bit", 32'(out_bit), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    @(posedge clk);
    #1;
    chk("rst_hold_valid", 32'(out_valid), 32'(0));
    rst_n = 1'b1;
  endtask

  initial begin
    bit acc;
    int pop;
    int thr;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_pop    = '0;
    in_last   = 1'b0;
    in_thr    = '0;
    out_ready = 1'b1;
    model_reset();
    #3;
    chk("reset_out_valid", 32'(out_valid), 32'(0));
    chk("reset_out_bit", 32'(out_bit), 32'(0));
    chk("reset_err", 32'(err), 32'(0));
    chk("reset_in_ready", 32'(in_ready), 32'(1));
    #9;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // dot = 0 against thr 0 and thr 1; all-zero pops against thr -512.
    neuron(64, 64, 64, 64, 0);
    idle(2);
    neuron(64, 64, 64, 64, 1);
    idle(2);
    neuron(0, 0, 0, 0, -512);
    idle(2);

    // Backpressure: second neuron's final beat must stall behind the pending result.
    out_ready = 1'b0;
    neuron(100, 90, 80, 70, 0);
    beat(10, 0, 0, 0);
    beat(20, 0, 0, 0);
    beat(30, 0, 0, 0);
    in_pop  = 8'd40;
    in_last = 1'b1;
    for (int i = 0; i < 8; i++) cyc(acc);
    out_ready = 1'b1;
    beat(40, 1, 0, 0);
    idle(3);

    // Streaming at full rate, all pops maximal.
    for (int n = 0; n < 3; n++) neuron(128, 128, 128, 128, 512);
    idle(2);

    // Misplaced in_last: error set, framing still follows the counter; error sticks.
    beat(10, 0, 0, 0);
    beat(10, 1, 0, 0);
    beat(10, 0, 0, 0);
    beat(10, 1, 0, 0);
    idle(2);
    neuron(128, 128, 128, 128, 0);
    idle(2);
    do_reset();

    // Out-of-range pop flags an error but is still summed.
    neuron(200, 0, 0, 0, -112);
    idle(2);
    do_reset();

    // Reset mid-neuron discards the partial sum.
    beat(5, 0, 0, 0);
    beat(5, 0, 0, 0);
    idle(1);
    do_reset();
    neuron(10, 10, 10, 10, -432);
    idle(2);
    neuron(10, 10, 10, 10, -431);
    idle(2);

    // Randomized traffic with random backpressure and gaps.
    for (int n = 0; n < 150; n++) begin
      thr = int'($urandom_range(0, 1100)) - 550;
      for (int b = 0; b < BEATS; b++) begin
        pop = int'($urandom_range(0, 128));
        beat(pop, (b == BEATS - 1), thr, 1);
      end
    end
    out_ready = 1'b1;
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
